// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// funct3 encodings, FSM state encoding and the request legality rule.
package mem_access_unit_pkg;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // A request is legal when funct3 is a supported width for its direction
  // and the address is naturally aligned for that width.
  function automatic logic req_legal(input logic       is_read,
                                     input logic [2:0] func3,
                                     input logic [1:0] addr_lo);
    logic legal_v;
    legal_v = 1'b0;
    case (func3)
      FUNC3_B:  legal_v = 1'b1;
      FUNC3_H:  legal_v = (addr_lo[0] == 1'b0);
      FUNC3_W:  legal_v = (addr_lo == 2'b00);
      FUNC3_BU: legal_v = is_read;
      FUNC3_HU: legal_v = is_read && (addr_lo[0] == 1'b0);
      default:  legal_v = 1'b0;
    endcase
    return legal_v;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends
// it according to the load funct3; also usable by forwarding logic.
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the low address bits
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extension by load type
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      FUNC3_B:  result = {{24{byte_s[7]}}, byte_s};
      FUNC3_H:  result = {{16{half_s[15]}}, half_s};
      FUNC3_W:  result = word;
      FUNC3_BU: result = {24'h00_0000, byte_s};
      FUNC3_HU: result = {16'h0000, half_s};
      default:  result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one req/ack memory access per
// load/store, stalls the pipeline meanwhile and formats the load result.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_DATA_MEM_READ,
  input  logic        MEM_DATA_MEM_WRITE,
  input  logic [2:0]  MEM_FUNC3,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_DATA2,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic [31:0] MEM_DATA_MEM_READ_DATA,
  output logic        MEM_BUSY,
  output logic        MEM_FAULT
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [2:0]  func3_r, func3_s;
  logic [1:0]  addr_lo_r, addr_lo_s;
  logic        dmem_req_r, dmem_req_s;
  logic        dmem_we_r, dmem_we_s;
  logic [31:0] dmem_addr_r, dmem_addr_s;
  logic [3:0]  dmem_be_r, dmem_be_s;
  logic [31:0] dmem_wdata_r, dmem_wdata_s;
  logic [31:0] rd_data_r, rd_data_s;
  logic        fault_r, fault_s;
  logic        busy_s;

  logic        req_s;
  logic        legal_s;
  logic [3:0]  st_be_s;
  logic [31:0] st_wdata_s;
  logic [31:0] fmt_s;

  assign req_s   = MEM_DATA_MEM_READ | MEM_DATA_MEM_WRITE;
  assign legal_s = req_legal(MEM_DATA_MEM_READ, MEM_FUNC3, MEM_ALU_OUT[1:0]);

  load_formatter u_load_formatter (
    .word    (DMEM_RDATA),
    .funct3  (func3_r),
    .addr_lo (addr_lo_r),
    .result  (fmt_s)
  );

  // Store byte enables and lane-replicated data; reads use a full-word enable
  always_comb begin
    st_be_s    = 4'b1111;
    st_wdata_s = 32'h0000_0000;
    if (MEM_DATA_MEM_READ) begin
      st_be_s    = 4'b1111;
      st_wdata_s = 32'h0000_0000;
    end else begin
      case (MEM_FUNC3)
        FUNC3_B: begin
          st_be_s    = 4'b0001 << MEM_ALU_OUT[1:0];
          st_wdata_s = {4{MEM_DATA2[7:0]}};
        end
        FUNC3_H: begin
          st_be_s    = 4'b0011 << {MEM_ALU_OUT[1], 1'b0};
          st_wdata_s = {2{MEM_DATA2[15:0]}};
        end
        default: begin
          st_be_s    = 4'b1111;
          st_wdata_s = MEM_DATA2;
        end
      endcase
    end
  end

  // Next-state and next-output logic of the access FSM
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    func3_s      = func3_r;
    addr_lo_s    = addr_lo_r;
    dmem_req_s   = dmem_req_r;
    dmem_we_s    = dmem_we_r;
    dmem_addr_s  = dmem_addr_r;
    dmem_be_s    = dmem_be_r;
    dmem_wdata_s = dmem_wdata_r;
    rd_data_s    = rd_data_r;
    fault_s      = 1'b0;
    busy_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && legal_s) begin
          busy_s       = 1'b1;
          state_s      = ACCESS;
          cnt_s        = 8'd0;
          func3_s      = MEM_FUNC3;
          addr_lo_s    = MEM_ALU_OUT[1:0];
          dmem_req_s   = 1'b1;
          dmem_we_s    = ~MEM_DATA_MEM_READ;
          dmem_addr_s  = {MEM_ALU_OUT[31:2], 2'b00};
          dmem_be_s    = st_be_s;
          dmem_wdata_s = st_wdata_s;
        end else if (req_s) begin
          fault_s   = 1'b1;
          rd_data_s = 32'h0000_0000;
        end else begin
          busy_s = 1'b0;
        end
      end
      ACCESS: begin
        busy_s = 1'b1;
        if (DMEM_ACK) begin
          dmem_req_s = 1'b0;
          state_s    = DONE;
          if (!dmem_we_r) begin
            rd_data_s = fmt_s;
          end else begin
            rd_data_s = rd_data_r;
          end
        end else if (cnt_r == TIMEOUT_LAST) begin
          dmem_req_s = 1'b0;
          fault_s    = 1'b1;
          rd_data_s  = 32'h0000_0000;
          state_s    = DONE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s    = IDLE;
        dmem_req_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs, with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      func3_r      <= 3'b000;
      addr_lo_r    <= 2'b00;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= 32'h0000_0000;
      dmem_be_r    <= 4'b0000;
      dmem_wdata_r <= 32'h0000_0000;
      rd_data_r    <= 32'h0000_0000;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      func3_r      <= func3_s;
      addr_lo_r    <= addr_lo_s;
      dmem_req_r   <= dmem_req_s;
      dmem_we_r    <= dmem_we_s;
      dmem_addr_r  <= dmem_addr_s;
      dmem_be_r    <= dmem_be_s;
      dmem_wdata_r <= dmem_wdata_s;
      rd_data_r    <= rd_data_s;
      fault_r      <= fault_s;
    end
  end

  assign DMEM_REQ               = dmem_req_r;
  assign DMEM_WE                = dmem_we_r;
  assign DMEM_ADDR              = dmem_addr_r;
  assign DMEM_BE                = dmem_be_r;
  assign DMEM_WDATA             = dmem_wdata_r;
  assign MEM_DATA_MEM_READ_DATA = rd_data_r;
  assign MEM_FAULT              = fault_r;
  assign MEM_BUSY               = busy_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random
// load/store transactions against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MEM_DATA_MEM_READ = 1'b0;
  logic        MEM_DATA_MEM_WRITE = 1'b0;
  logic [2:0]  MEM_FUNC3 = 3'b000;
  logic [31:0] MEM_ALU_OUT = 32'h0;
  logic [31:0] MEM_DATA2 = 32'h0;
  logic        DMEM_REQ, DMEM_WE, MEM_BUSY, MEM_FAULT;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, MEM_DATA_MEM_READ_DATA;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA = 32'h0;
  logic        DMEM_ACK = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = 32'h0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_DATA_MEM_READ(MEM_DATA_MEM_READ), .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE),
    .MEM_FUNC3(MEM_FUNC3), .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_DATA2(MEM_DATA2),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .MEM_DATA_MEM_READ_DATA(MEM_DATA_MEM_READ_DATA), .MEM_BUSY(MEM_BUSY),
    .MEM_FAULT(MEM_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load result by arithmetic on the addressed lane
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic rd, input logic [2:0] f3, input int a);
    int size;
    logic ok;
    ok = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
    return ok && ((a % size) == 0);
  endfunction

  task automatic clear_inputs();
    MEM_DATA_MEM_READ = 1'b0;
    MEM_DATA_MEM_WRITE = 1'b0;
  endtask

  // One instruction in MEM; delay = ACCESS cycle index of the ack, >= TO means never
  task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data2,
                        input int delay, input logic [31:0] rdata);
    logic req, legal, timed, isrd;
    logic [3:0] ebe;
    logic [31:0] ewd;
    int a, busy_n, exp_busy;
    req   = rd | wr;
    isrd  = rd;
    a     = int'(addr % 32'd4);
    legal = req && ref_legal(isrd, f3, a);
    timed = (delay >= TO);
    ebe = 4'b1111;
    ewd = 32'h0;
    if (!isrd) begin
      if (f3 == 3'd0) begin ebe = 4'b0001 << a; ewd = (data2 & 32'hFF) * 32'h0101_0101; end
      else if (f3 == 3'd1) begin ebe = 4'b0011 << (a & 2); ewd = (data2 & 32'hFFFF) * 32'h0001_0001; end
      else ewd = data2;
    end
    @(negedge CLK);
    MEM_DATA_MEM_READ = rd; MEM_DATA_MEM_WRITE = wr;
    MEM_FUNC3 = f3; MEM_ALU_OUT = addr; MEM_DATA2 = data2;
    DMEM_ACK = !req && ($urandom_range(0, 1) == 1);
    DMEM_RDATA = $urandom;
    #1 check_val("busy_idle", {31'b0, MEM_BUSY}, {31'b0, legal});
    if (!req) begin
      @(negedge CLK);
      DMEM_ACK = 1'b0;
      check_val("idle_req", {31'b0, DMEM_REQ}, 32'h0);
      check_val("idle_fault", {31'b0, MEM_FAULT}, 32'h0);
      check_val("idle_rdata", MEM_DATA_MEM_READ_DATA, exp_rd);
      return;
    end
    if (!legal) begin
      @(negedge CLK);
      exp_rd = 32'h0;
      check_val("ill_fault", {31'b0, MEM_FAULT}, 32'h1);
      check_val("ill_req", {31'b0, DMEM_REQ}, 32'h0);
      check_val("ill_rdata", MEM_DATA_MEM_READ_DATA, exp_rd);
      clear_inputs();
      @(negedge CLK);
      check_val("ill_fault_end", {31'b0, MEM_FAULT}, 32'h0);
      return;
    end
    @(negedge CLK);
    check_val("acc_req", {31'b0, DMEM_REQ}, 32'h1);
    check_val("acc_we", {31'b0, DMEM_WE}, {31'b0, !isrd});
    check_val("acc_addr", DMEM_ADDR, addr & 32'hFFFF_FFFC);
    check_val("acc_be", {28'b0, DMEM_BE}, {28'b0, ebe});
    check_val("acc_wdata", DMEM_WDATA, ewd);
    busy_n = 1;
    for (int k = 0; k < TO; k++) begin
      if (MEM_BUSY) busy_n++;
      if (k == delay) begin DMEM_ACK = 1'b1; DMEM_RDATA = rdata; end
      else DMEM_RDATA = $urandom;
      @(negedge CLK);
      DMEM_ACK = 1'b0;
      if (k == delay) break;
    end
    if (timed) exp_rd = 32'h0;
    else if (isrd) exp_rd = ref_load(f3, a, rdata);
    exp_busy = timed ? 1 + TO : 2 + delay;
    check_val("busy_cycles", busy_n, exp_busy);
    check_val("done_busy", {31'b0, MEM_BUSY}, 32'h0);
    check_val("done_req", {31'b0, DMEM_REQ}, 32'h0);
    check_val("done_fault", {31'b0, MEM_FAULT}, {31'b0, timed});
    check_val("done_rdata", MEM_DATA_MEM_READ_DATA, exp_rd);
    DMEM_ACK = 1'b1;
    @(negedge CLK);
    DMEM_ACK = 1'b0;
    check_val("no_reissue", {31'b0, DMEM_REQ}, 32'h0);
    check_val("post_fault", {31'b0, MEM_FAULT}, 32'h0);
    check_val("post_rdata", MEM_DATA_MEM_READ_DATA, exp_rd);
    clear_inputs();
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_val("rst_req", {31'b0, DMEM_REQ}, 32'h0);
    check_val("rst_we", {31'b0, DMEM_WE}, 32'h0);
    check_val("rst_addr", DMEM_ADDR, 32'h0);
    check_val("rst_be", {28'b0, DMEM_BE}, 32'h0);
    check_val("rst_wdata", DMEM_WDATA, 32'h0);
    check_val("rst_rdata", MEM_DATA_MEM_READ_DATA, 32'h0);
    check_val("rst_fault", {31'b0, MEM_FAULT}, 32'h0);
    RESET = 1'b1;

    do_txn(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 2, 32'h80FF_1234);
    check_val("lb_value", MEM_DATA_MEM_READ_DATA, 32'hFFFF_FF80);
    do_txn(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0, 0, 32'h8001_0000);
    check_val("lhu_value", MEM_DATA_MEM_READ_DATA, 32'h0000_8001);
    do_txn(1'b0, 1'b1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 1, 32'h0);
    check_val("sb_keeps_rdata", MEM_DATA_MEM_READ_DATA, 32'h0000_8001);
    do_txn(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0, 0, 32'h0);
    do_txn(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0, 99, 32'h1234_5678);
    do_txn(1'b1, 1'b1, 3'd2, 32'h0000_0400, 32'h5555_5555, 0, 32'hCAFE_F00D);
    do_txn(1'b0, 1'b1, 3'd4, 32'h0000_0400, 32'h1, 0, 32'h0);

    // Reset in the middle of an access, then a late ack
    @(negedge CLK);
    MEM_DATA_MEM_READ = 1'b1; MEM_FUNC3 = 3'd2; MEM_ALU_OUT = 32'h0000_0040;
    @(negedge CLK);
    check_val("mid_req", {31'b0, DMEM_REQ}, 32'h1);
    RESET = 1'b0;
    @(negedge CLK);
    check_val("mid_rst_req", {31'b0, DMEM_REQ}, 32'h0);
    check_val("mid_rst_rdata", MEM_DATA_MEM_READ_DATA, 32'h0);
    RESET = 1'b1;
    clear_inputs();
    exp_rd = 32'h0;
    @(negedge CLK);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hDEAD_BEEF;
    #1 check_val("late_busy", {31'b0, MEM_BUSY}, 32'h0);
    @(negedge CLK);
    DMEM_ACK = 1'b0;
    check_val("late_ack_rdata", MEM_DATA_MEM_READ_DATA, 32'h0);
    check_val("late_ack_req", {31'b0, DMEM_REQ}, 32'h0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      do_txn(kind == 2'd1 || kind == 2'd3, kind == 2'd2 || kind == 2'd3,
             3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 5)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, between the EX/MEM and MEM/WB pipeline registers.
- Takes the load/store request of the instruction currently in MEM and runs a req/ack handshake with data memory.
- Generates store byte-enables and lane-replicated store data, and formats load data (sign/zero extension) into MEM_DATA_MEM_READ_DATA for MEM/WB.
- Asserts MEM_BUSY to stall the pipeline until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ACCESS without DMEM_ACK before the access is aborted with a fault (1..255).

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  synchronous active-low reset (asserted when 0)
MEM_DATA_MEM_READ  in  1  load request from EX/MEM
MEM_DATA_MEM_WRITE  in  1  store request from EX/MEM
MEM_FUNC3  in  3  RV32 funct3 of the load/store
MEM_ALU_OUT  in  32  effective byte address
MEM_DATA2  in  32  store source (rs2)
DMEM_REQ  out  1  memory request, registered
DMEM_WE  out  1  1 = write, registered
DMEM_ADDR  out  32  word address {addr[31:2],2'b00}, registered
DMEM_BE  out  4  byte enables, registered
DMEM_WDATA  out  32  lane-replicated store data, registered
DMEM_RDATA  in  32  read word, valid with DMEM_ACK
DMEM_ACK  in  1  one-cycle completion strobe
MEM_DATA_MEM_READ_DATA  out  32  formatted load result to MEM/WB, registered
MEM_BUSY  out  1  stall request to PC and pipeline registers
MEM_FAULT  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout

Behaviour:
Reset:
- RESET=0 at an edge forces state IDLE and timeout counter 0.
- All registered outputs go to 0: DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA, MEM_DATA_MEM_READ_DATA, MEM_FAULT.
- This holds in any state, including mid-ACCESS. A late DMEM_ACK arriving after reset is ignored.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- Request = MEM_DATA_MEM_READ | MEM_DATA_MEM_WRITE. If both are set, read wins and the write is ignored.
- Legal request: MEM_BUSY=1 combinationally. At the edge, latch DMEM_ADDR/BE/WDATA/WE, set DMEM_REQ=1, save FUNC3 and addr[1:0], clear counter, go to ACCESS.
- Illegal request (misaligned halfword addr[0]=1, misaligned word addr[1:0]!=0, or funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores): no memory access, MEM_BUSY=0, MEM_FAULT=1 for the next cycle, MEM_DATA_MEM_READ_DATA<=0, stay IDLE.
- No request: MEM_BUSY=0.

ACCESS:
- MEM_BUSY=1. DMEM_* outputs are held stable.
- DMEM_ACK=1 at an edge: DMEM_REQ<=0. If a read, MEM_DATA_MEM_READ_DATA<=formatted DMEM_RDATA; a write leaves it unchanged. Go to DONE.
- Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without ack: DMEM_REQ<=0, MEM_FAULT pulses, read data<=0, go to DONE.

DONE:
- MEM_BUSY=0 for exactly one cycle, so the pipeline advances and MEM/WB captures the result.
- Go unconditionally to IDLE. Inputs still showing the completed request are not re-issued.
- DMEM_ACK in IDLE or DONE is ignored.

Latency: a zero-wait memory (ack in the first ACCESS cycle) takes 3 cycles per access; non-memory instructions take 0 stall cycles.

Store formatting:
- SB: BE=4'b0001<<addr[1:0], WDATA={4{rs2[7:0]}}.
- SH: BE=4'b0011<<{addr[1],1'b0}, WDATA={2{rs2[15:0]}}.
- SW: BE=4'b1111, WDATA=rs2.
- Read requests: BE=4'b1111, WDATA=0.

Load formatting: select the byte/half lane using the saved addr[1:0].
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: word unchanged.

Decomposition:
- Shared package holds:
  - funct3 constants: FUNC3_B=3'b000, FUNC3_H=3'b001, FUNC3_W=3'b010, FUNC3_BU=3'b100, FUNC3_HU=3'b101.
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- One combinational sub-module, load_formatter (inputs: word, funct3, addr[1:0]; output: 32-bit result), also reusable by forwarding logic.
- Store BE/WDATA generation stays inline.

Test Plan:
- LB at addr 0x103, DMEM_RDATA=0x80FF_1234, ack after 2 cycles -> MEM_BUSY high 4 cycles; READ_DATA=0xFFFF_FF80; DMEM_ADDR=0x100.
- LHU at 0x102, RDATA=0x8001_0000, immediate ack -> READ_DATA=0x0000_8001; BUSY high exactly 2 cycles.
- SB at 0x201 with rs2=0x0000_00AB -> DMEM_WE=1, BE=4'b0010, WDATA=0xABAB_ABAB, ADDR=0x200; READ_DATA unchanged.
- LW at 0x102 -> no DMEM_REQ, MEM_FAULT pulses 1 cycle, BUSY never asserted, READ_DATA=0.
- Load with ack never asserted, TIMEOUT_CYCLES=4 -> DMEM_REQ drops after 4 ACCESS cycles, MEM_FAULT pulse, READ_DATA=0, then DONE->IDLE.
- RESET=0 during ACCESS, then ack arrives 1 cycle after release -> DMEM_REQ=0, state IDLE, ack ignored, READ_DATA=0.
